multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have no parameters; all encodings are fixed constants.
REQ-002 SHALL have port clk  input  1  single system clock, rising-edge active.
REQ-003 SHALL have port reset  input  1  reset, synchronous to clk and active-high.
REQ-004 SHALL have port op  input  7  instruction opcode, instr[6:0] from the instruction register.
REQ-005 SHALL have port funct3  input  3  instr[14:12].
REQ-006 SHALL have port funct7_5  input  1  instr[30].
REQ-007 SHALL have port zero  input  1  ALU zero flag of the current cycle.
REQ-008 SHALL have port pc_write  output  1  PC register enable.
REQ-009 SHALL have port adr_src  output  1  memory address mux select: 0 = PC, 1 = ALUOut.
REQ-010 SHALL have port ir_write  output  1  instruction register and OldPC enable.
REQ-011 SHALL have port mem_write  output  1  data memory write enable.
REQ-012 SHALL have port reg_write  output  1  register file write enable.
REQ-013 SHALL have port alu_src_a  output  2  ALU A mux select: 00 = PC, 01 = OldPC, 10 = RD1.
REQ-014 SHALL have port alu_src_b  output  2  ALU B mux select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
REQ-015 SHALL have port result_src  output  2  result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-016 SHALL have port alu_control  output  3  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
REQ-017 SHALL have port imm_src  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
REQ-018 SHALL have port state_dbg  output  4  current FSM state code, for test benches only.

Function
REQ-019 SHALL implement a Moore FSM with these states and codes:
- FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5
- EXECR = 6, ALUWB = 7, EXECI = 8, JAL = 9, BEQ = 10
REQ-020 SHALL register state on the rising clk edge; all outputs are combinational from state, op, funct3, funct7_5 and zero.
REQ-021 SHALL always go FETCH -> DECODE.
REQ-022 SHALL branch from DECODE on op:
- 0000011 (lw) or 0100011 (sw) -> MEMADR
- 0110011 (R-type) -> EXECR
- 0010011 (I-type ALU) -> EXECI
- 1101111 (jal) -> JAL
- 1100011 (beq) -> BEQ
- any other op -> FETCH, with no register or memory write.
REQ-023 SHALL go MEMADR -> MEMREAD for lw and MEMADR -> MEMWRITE for sw.
REQ-024 SHALL go MEMREAD -> MEMWB, then MEMWB -> FETCH.
REQ-025 SHALL go MEMWRITE -> FETCH.
REQ-026 SHALL go EXECR -> ALUWB, EXECI -> ALUWB and JAL -> ALUWB.
REQ-027 SHALL go ALUWB -> FETCH and BEQ -> FETCH.
REQ-028 SHALL give FETCH outputs: adr_src = 0, ir_write = 1, alu_src_a = 00, alu_src_b = 10, alu add, result_src = 10, pc_write = 1.
REQ-029 SHALL give DECODE outputs: alu_src_a = 01, alu_src_b = 01, alu add (branch target precompute).
REQ-030 SHALL give MEMADR outputs: alu_src_a = 10, alu_src_b = 01, alu add.
REQ-031 SHALL give MEMREAD outputs: result_src = 00, adr_src = 1.
REQ-032 SHALL give MEMWRITE outputs: result_src = 00, adr_src = 1, mem_write = 1.
REQ-033 SHALL give MEMWB outputs: result_src = 01, reg_write = 1.
REQ-034 SHALL give EXECR outputs: alu_src_a = 10, alu_src_b = 00, function-decoded ALU.
REQ-035 SHALL give EXECI outputs: alu_src_a = 10, alu_src_b = 01, function-decoded ALU.
REQ-036 SHALL give ALUWB outputs: result_src = 00, reg_write = 1.
REQ-037 SHALL give JAL outputs: alu_src_a = 01, alu_src_b = 10, alu add, result_src = 00, pc_write = 1.
REQ-038 SHALL give BEQ outputs: alu_src_a = 10, alu_src_b = 00, alu sub, result_src = 00, pc_write = zero.
REQ-039 SHALL drive every output not listed for a state to 0.
REQ-040 SHALL function-decode the ALU as follows:
- funct3 000 -> sub when op[5] & funct7_5, otherwise add
- funct3 010 -> slt
- funct3 110 -> or
- funct3 111 -> and
- any other funct3 -> add.
REQ-041 SHALL decode imm_src from op in every state: sw -> 01, beq -> 10, jal -> 11, all other ops -> 00.
REQ-042 SHALL take these cycle counts per instruction: lw 5, sw 4, R-type 4, I-type ALU 4, jal 4, beq 3, unsupported op 2.

Reset
REQ-043 SHALL, with reset high at a rising edge, force state = FETCH and override any transition, including mid-instruction.
REQ-044 SHALL hold mem_write = 0 and reg_write = 0 in the first cycle after reset is released.
REQ-045 SHALL present FETCH outputs while reset is held high.
REQ-046 SHALL return any unreachable state code (11-15) to FETCH on the next edge.

Structure
REQ-047 SHALL take state codes, opcode constants and mux-select encodings from a shared include file, riscv_defs.vh, also used by the datapath muxes.
REQ-048 SHALL place the ALU decoder (REQ-040) in its own sub-module, alu_decoder.
REQ-049 SHALL contain no datapath logic.

Verification
REQ-050 SHALL cover lw (op 0000011) after reset: state sequence 0,1,2,3,4,0; reg_write = 1 only in state 4.
REQ-051 SHALL cover sw (op 0100011): sequence 0,1,2,5,0; mem_write = 1 only in state 5; imm_src = 01.
REQ-052 SHALL cover R-type sub (funct3 000, funct7_5 = 1): alu_control = 001 in EXECR; with funct7_5 = 0, alu_control = 000.
REQ-053 SHALL cover beq with zero = 1: pc_write = 1 in BEQ; with zero = 0: pc_write = 0; both cases return to FETCH.
REQ-054 SHALL cover illegal op 1111111: sequence 0,1,0 with no write enable asserted.
REQ-055 SHALL cover reset asserted during MEMREAD: next state 0, mem_write and reg_write stay 0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
//------------------------------------------------------------------------------
// multicycle_control_pkg
// Shared state codes, opcodes and mux-select encodings for the multicycle core.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package multicycle_control_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_EXECI    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_decoder.sv
//------------------------------------------------------------------------------
// alu_decoder
// Maps funct3/funct7_5 (and op[5] to tell R-type from I-type) to an ALU code.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (funct3)
      // addi never subtracts: op[5] is clear for I-type, so imm bit 30 is ignored
      3'b000:  alu_control = (op5 & funct7_5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_control = ALU_SLT;
      3'b110:  alu_control = ALU_OR;
      3'b111:  alu_control = ALU_AND;
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
//------------------------------------------------------------------------------
// multicycle_control
// Moore control FSM for a multicycle RV32I subset (lw/sw/R/I/jal/beq).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic [3:0] state_dbg
);

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  logic [3:0] w_out_state;
  logic [2:0] w_alu_func;

  alu_decoder u_alu_decoder (
    .op5         (op[5]),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .alu_control (w_alu_func)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:  w_next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RTYPE:     w_next_state = S_EXECR;
          OP_ITYPE:     w_next_state = S_EXECI;
          OP_JAL:       w_next_state = S_JAL;
          OP_BEQ:       w_next_state = S_BEQ;
          default:      w_next_state = S_FETCH;
        endcase
      end
      S_MEMADR:  w_next_state = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: w_next_state = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL: w_next_state = S_ALUWB;
      default:   w_next_state = S_FETCH;
    endcase
  end

  // Holding reset presents FETCH controls even before the first clock edge
  assign w_out_state = reset ? S_FETCH : r_state;
  assign state_dbg   = r_state;

  always_comb begin
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RD2;
    result_src  = RES_ALUOUT;
    alu_control = ALU_ADD;
    imm_src     = imm_src_of(op);
    case (w_out_state)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        pc_write   = 1'b1;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_EXECR: begin
        alu_src_a   = SRCA_RD1;
        alu_control = w_alu_func;
      end
      S_EXECI: begin
        alu_src_a   = SRCA_RD1;
        alu_src_b   = SRCB_IMM;
        alu_control = w_alu_func;
      end
      S_ALUWB: reg_write = 1'b1;
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      S_BEQ: begin
        alu_src_a   = SRCA_RD1;
        alu_control = ALU_SUB;
        pc_write    = zero;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire
